// File: rtl/oo_arb_pkg.sv
// Shared types and sizes for the four-way round-robin arbiter.
package oo_arb_pkg;

   typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

   localparam int unsigned ARB_N   = 4;
   localparam int unsigned ARB_IDW = 2;

endpackage : oo_arb_pkg

// File: rtl/decoder2x4.sv
// 2-to-4 one-hot decoder with enable.
//  en   in  1  output all-zero when low
//  sel  in  2  selected line
//  y    out 4  one-hot result
module decoder2x4 (
   input  logic       en,
   input  logic [1:0] sel,
   output logic [3:0] y
);

   always_comb begin
      y = 4'b0000;
      if (en) y = 4'b0001 << sel;
   end

endmodule : decoder2x4

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first set request bit at or after ptr, wrapping 3->0.
//  req  in  4  candidate requests
//  ptr  in  2  highest-priority index
//  any  out 1  at least one request set
//  idx  out 2  index of the winner (0 when none)
module rr_pick4
   import oo_arb_pkg::*;
(
   input  logic [ARB_N-1:0]   req,
   input  logic [ARB_IDW-1:0] ptr,
   output logic               any,
   output logic [ARB_IDW-1:0] idx
);

   logic               found;
   logic [ARB_IDW-1:0] cand;

   // Scan priority order ptr, ptr+1, ptr+2, ptr+3; 2-bit add wraps naturally.
   always_comb begin
      any   = |req;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int i = 0; i < int'(ARB_N); i++) begin
         cand = ptr + ARB_IDW'(i);
         if (!found && req[cand]) begin
            idx   = cand;
            found = 1'b1;
         end
      end
   end

endmodule : rr_pick4

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter sharing one resource among four requesters. A holder keeps the
// grant until done, until it drops its request, or until MAX_HOLD cycles elapse.
//  clk          in  1  rising-edge clock
//  reset        in  1  asynchronous active-high reset
//  req          in  4  level requests
//  done         in  1  holder finished (ignored when idle)
//  grant        out 4  one-hot grant, decoded from the registered id/valid
//  grant_id     out 2  current holder index, meaningful while grant_valid
//  grant_valid  out 1  a holder exists
//  timeout      out 1  one-cycle pulse after a forced release
module rr_arbiter4
   import oo_arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [ARB_N-1:0]   req,
   input  logic               done,
   output logic [ARB_N-1:0]   grant,
   output logic [ARB_IDW-1:0] grant_id,
   output logic               grant_valid,
   output logic               timeout
);

   localparam int unsigned CNT_W = $clog2(MAX_HOLD);

   arb_state_t         state, state_nxt;
   logic [ARB_IDW-1:0] ptr, ptr_nxt;
   logic [ARB_IDW-1:0] id_nxt;
   logic               valid_nxt;
   logic               timeout_nxt;
   logic [CNT_W-1:0]   hold_cnt, hold_cnt_nxt;

   logic               idle_any;
   logic [ARB_IDW-1:0] idle_idx;
   logic               rel_any;
   logic [ARB_IDW-1:0] rel_idx;
   logic [ARB_N-1:0]   rel_req;
   logic [ARB_IDW-1:0] rel_ptr;

   logic               at_limit;
   logic               withdraw;
   logic               release_now;

   // Release pick: holder masked off, priority starts just past the holder.
   assign rel_req = req & ~(4'b0001 << grant_id);
   assign rel_ptr = grant_id + 2'd1;

   rr_pick4 u_pick_idle (
      .req (req),
      .ptr (ptr),
      .any (idle_any),
      .idx (idle_idx)
   );

   rr_pick4 u_pick_rel (
      .req (rel_req),
      .ptr (rel_ptr),
      .any (rel_any),
      .idx (rel_idx)
   );

   decoder2x4 u_dec (
      .en  (grant_valid),
      .sel (grant_id),
      .y   (grant)
   );

   assign at_limit    = (hold_cnt == CNT_W'(MAX_HOLD - 1));
   assign withdraw    = ~req[grant_id];
   assign release_now = done | withdraw | at_limit;

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ARB_IDLE;
         grant_id    <= '0;
         grant_valid <= 1'b0;
         timeout     <= 1'b0;
         ptr         <= '0;
         hold_cnt    <= '0;
      end else begin
         state       <= state_nxt;
         grant_id    <= id_nxt;
         grant_valid <= valid_nxt;
         timeout     <= timeout_nxt;
         ptr         <= ptr_nxt;
         hold_cnt    <= hold_cnt_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt    = state;
      id_nxt       = grant_id;
      valid_nxt    = grant_valid;
      timeout_nxt  = 1'b0;
      ptr_nxt      = ptr;
      hold_cnt_nxt = hold_cnt;

      case (state)
         ARB_IDLE: begin
            if (idle_any) begin
               state_nxt    = ARB_GRANT;
               id_nxt       = idle_idx;
               valid_nxt    = 1'b1;
               hold_cnt_nxt = '0;
            end
         end

         ARB_GRANT: begin
            if (release_now) begin
               ptr_nxt      = rel_ptr;
               hold_cnt_nxt = '0;
               // Only a pure hold-limit release is reported as a timeout.
               timeout_nxt  = at_limit & ~done & ~withdraw;
               if (rel_any) begin
                  id_nxt = rel_idx;
               end else begin
                  state_nxt = ARB_IDLE;
                  valid_nxt = 1'b0;
               end
            end else if (!at_limit) begin
               hold_cnt_nxt = hold_cnt + CNT_W'(1);
            end
         end

         default: begin
            state_nxt = ARB_IDLE;
            valid_nxt = 1'b0;
         end
      endcase
   end

endmodule : rr_arbiter4

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: inputs change after the falling edge, outputs are
// checked at the next falling edge (one rising edge later).
module tb_rr_arbiter4;

   logic       clk;
   logic       reset;
   logic [3:0] req;
   logic       done;
   logic [3:0] grant;
   logic [1:0] grant_id;
   logic       grant_valid;
   logic       timeout;

   int n_chk;
   int n_err;

   rr_arbiter4 #(.MAX_HOLD(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .done        (done),
      .grant       (grant),
      .grant_id    (grant_id),
      .grant_valid (grant_valid),
      .timeout     (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected {timeout, valid, id, grant} from a one-hot grant; id is 0 when no grant.
   function automatic logic [7:0] expv(input logic to, input logic [3:0] g);
      logic [1:0] id;
      case (g)
         4'b0010: id = 2'd1;
         4'b0100: id = 2'd2;
         4'b1000: id = 2'd3;
         default: id = 2'd0;
      endcase
      return {to, |g, id, g};
   endfunction

   task automatic chk(input string tag, input logic to, input logic [3:0] g);
      logic [7:0] obs;
      logic [7:0] exp_v;
      exp_v = expv(to, g);
      obs   = {timeout, grant_valid, (grant_valid ? grant_id : 2'b00), grant};
      n_chk++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed to/v/id/grant=%b expected=%b", tag, obs, exp_v);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_chk = 0;
      n_err = 0;
      reset = 1'b1;
      req   = 4'b1111;
      done  = 1'b0;

      // 1: outputs held low in reset, first grant one cycle after release
      @(negedge clk);
      chk("reset_hold", 1'b0, 4'b0000);
      reset = 1'b0;
      @(negedge clk);
      chk("first_grant", 1'b0, 4'b0001);

      // 2: done every cycle rotates through all four with no bubble
      done = 1'b1;
      @(negedge clk); chk("rot_1", 1'b0, 4'b0010);
      @(negedge clk); chk("rot_2", 1'b0, 4'b0100);
      @(negedge clk); chk("rot_3", 1'b0, 4'b1000);
      @(negedge clk); chk("rot_wrap", 1'b0, 4'b0001);

      // 3: reach IDLE with ptr=2, then req=0011 must wrap to requester 0
      req = 4'b0010;
      @(negedge clk); chk("to_id1", 1'b0, 4'b0010);
      done = 1'b0;
      req  = 4'b0000;
      @(negedge clk); chk("idle_ptr2", 1'b0, 4'b0000);
      req = 4'b0011;
      @(negedge clk); chk("wrap_pick", 1'b0, 4'b0001);
      req  = 4'b0010;
      done = 1'b1;
      @(negedge clk); chk("done_next", 1'b0, 4'b0010);
      done = 1'b0;

      // 4: holder 2 keeps the grant 16 cycles, then a forced release with timeout
      req = 4'b0100;
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         chk($sformatf("hold_%0d", i), 1'b0, 4'b0100);
         if (i == 10) req = 4'b0101;
      end
      @(negedge clk); chk("timeout_pulse", 1'b1, 4'b0001);
      // holder 0 runs to its limit; done on the limit cycle suppresses timeout
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk);
         chk($sformatf("hold0_%0d", i), 1'b0, 4'b0001);
      end
      done = 1'b1;
      @(negedge clk); chk("done_at_limit", 1'b0, 4'b0100);

      // 5: withdraw hands over without timeout; done while idle is ignored
      req = 4'b0010;
      @(negedge clk); chk("to_id1_again", 1'b0, 4'b0010);
      done = 1'b0;
      req  = 4'b1000;
      @(negedge clk); chk("withdraw", 1'b0, 4'b1000);
      req = 4'b0000;
      @(negedge clk); chk("withdraw_idle", 1'b0, 4'b0000);
      done = 1'b1;
      @(negedge clk); chk("done_idle_1", 1'b0, 4'b0000);
      @(negedge clk); chk("done_idle_2", 1'b0, 4'b0000);
      done = 1'b0;

      // 6: reset mid-grant drops grant without waiting for a clock
      req = 4'b0100;
      @(negedge clk); chk("pre_reset", 1'b0, 4'b0100);
      #2 reset = 1'b1;
      #1 chk("async_drop", 1'b0, 4'b0000);
      @(negedge clk); chk("in_reset", 1'b0, 4'b0000);
      reset = 1'b0;
      @(negedge clk); chk("post_reset", 1'b0, 4'b0100);
      reset = 1'b1;
      req   = 4'b1111;
      @(negedge clk); chk("reset_again", 1'b0, 4'b0000);
      reset = 1'b0;
      @(negedge clk); chk("ptr_reset", 1'b0, 4'b0001);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule : tb_rr_arbiter4
